// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nibble_serial_addsub_pkg;

    // Width of one arithmetic slice.
    localparam int NIBBLE_W = 4;

    // Operation select encodings on the mode input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : nibble_serial_addsub_pkg

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle between a requester and the add/sub sequencer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface nibble_serial_addsub_if
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    // Request side
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;

    // Result side
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    // Status
    logic         busy;

    // Requester / consumer view
    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, carry, overflow, busy
    );

    // Sequencer view
    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, carry, overflow, busy
    );

endinterface : nibble_serial_addsub_if

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit add/subtract slice; subtract inverts b4 and relies on cin=1 from the caller.
// Latency: zero cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
module nibble_addsub_slice
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                mode,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s4,
    output logic                cout,
    output logic                c_msb_in
);

    logic [NIBBLE_W-1:0] b_x;      // b4, inverted when subtracting
    logic [NIBBLE_W-1:0] low_sum;  // {carry into bit 3, sum bits 2:0}
    logic [1:0]          msb_sum;  // {carry out, sum bit 3}

    assign b_x = b4 ^ {NIBBLE_W{mode == MODE_SUB}};

    // Split at bit 3 so the carry into the MSB is visible for overflow detection.
    assign low_sum = {1'b0, a4[2:0]} + {1'b0, b_x[2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};
    assign msb_sum = {1'b0, a4[3]} + {1'b0, b_x[3]} + {1'b0, low_sum[3]};

    assign s4       = {msb_sum[0], low_sum[2:0]};
    assign cout     = msb_sum[1];
    assign c_msb_in = low_sum[3];

endmodule : nibble_addsub_slice

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract sequencer driving one 4-bit slice per clock, LS nibble first.
// Latency: accept at edge k, out_valid after edge k+NIBBLES; one op per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Overflow logic under NIBBLE_SERIAL_ADDSUB_OVF_EN.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_addsub_if.slave  bus
);

    localparam int             W        = NIBBLE_W * NIBBLES;
    localparam int             IDX_W    = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Architectural state
    state_t            state_q,  state_d;
    logic [W-1:0]      a_q,      a_d;
    logic [W-1:0]      b_q,      b_d;
    logic              mode_q,   mode_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              carry_q,  carry_d;
    logic [W-1:0]      result_q, result_d;

    // Time-multiplexed slice datapath
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                slice_cout;

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
    logic msb_cin;
`else
    logic msb_cin_unused;
`endif

    // Select the operand nibbles for the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_addsub_slice u_slice (
        .a4       (a_nib),
        .b4       (b_nib),
        .mode     (mode_q),
        .cin      (carry_q),
        .s4       (s_nib),
        .cout     (slice_cout),
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
        .c_msb_in (msb_cin)
`else
        .c_msb_in (msb_cin_unused)
`endif
    );

    // Next-state logic: capture in IDLE, one nibble per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    mode_d   = bus.mode;
                    idx_d    = '0;
                    // Seeding the carry with mode turns A + ~B into A - B.
                    carry_d  = (bus.mode == MODE_SUB);
                    result_d = '0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        result_d[n*NIBBLE_W +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
                    // Signed overflow: carries into and out of the top bit disagree.
                    ovf_d = msb_cin ^ slice_cout;
`endif
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Handshake and status outputs decode from state only.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    assign bus.overflow  = ovf_q;
`else
    assign bus.overflow  = 1'b0;
`endif

endmodule : nibble_serial_addsub
